// File: rtl/pvs_event_pkg.sv
// rtl/pvs_event_pkg.sv - shared constants and FSM state type for the event stamper
package pvs_event_pkg;

  // Header bit positions, one per event pin
  localparam int HDR_AP = 0;
  localparam int HDR_VP = 1;
  localparam int HDR_RV = 2;
  localparam int HDR_RA = 3;

  localparam int NUM_CH   = 4;
  localparam int HEADER_W = 8;
  localparam int TS_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/event_stamper_if.sv
// rtl/event_stamper_if.sv - event pins in, header/timestamp strobe out
// master: the stamper (samples pins, drives header/counter/event_valid)
// slave : the environment (drives pins, consumes the strobe)
interface event_stamper_if;

  logic                               ap_pin;
  logic                               vp_pin;
  logic                               rv_pin;
  logic                               ra_pin;
  logic [pvs_event_pkg::HEADER_W-1:0] header;
  logic [pvs_event_pkg::TS_W-1:0]     counter;
  logic                               event_valid;

  modport master (
    input  ap_pin, vp_pin, rv_pin, ra_pin,
    output header, counter, event_valid
  );

  modport slave (
    output ap_pin, vp_pin, rv_pin, ra_pin,
    input  header, counter, event_valid
  );

endinterface

// File: rtl/channel_qualifier.sv
// rtl/channel_qualifier.sv - per-pin synchroniser, rising-edge detect and retrigger blanking
// clk, rst : tick clock, synchronous active-high reset
// pin      : asynchronous event level
// accept   : one-cycle pulse for an edge that passed blanking
module channel_qualifier #(
  parameter logic [31:0] BLANK_TICKS = 32'd150
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic accept
);

  logic        q1, q2, q3;
  logic        edge_det;
  logic [31:0] blank_cnt;

  assign edge_det = q2 & ~q3;
  // A count of 1 means the counter reaches zero this cycle, so the edge counts.
  assign accept   = edge_det && (blank_cnt <= 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q1        <= 1'b0;
      q2        <= 1'b0;
      q3        <= 1'b0;
      blank_cnt <= '0;
    end else begin
      q1 <= pin;
      q2 <= q1;
      q3 <= q2;
      if (accept)
        blank_cnt <= BLANK_TICKS;
      else if (blank_cnt != 32'd0)
        blank_cnt <= blank_cnt - 32'd1;
    end
  end

endmodule

// File: rtl/event_stamper.sv
// rtl/event_stamper.sv - coalesces qualified pin edges into timestamped header strobes
// clk, rst : tick clock, synchronous active-high reset
// bus      : pins in; header, counter (timestamp of last event), event_valid out
module event_stamper
  import pvs_event_pkg::*;
#(
  parameter logic [31:0]     BLANK_TICKS = 32'd150,
  parameter logic [7:0]      MERGE_TICKS = 8'd15,
  parameter logic [TS_W-1:0] TS_INIT     = '0
) (
  input  logic           clk,
  input  logic           rst,
  event_stamper_if.master bus
);

  logic [NUM_CH-1:0]   pins;
  logic [NUM_CH-1:0]   accept;
  logic                any_accept;

  logic [TS_W-1:0]     ts;
  state_t              state, state_d;
  logic [7:0]          win_cnt, win_cnt_d;
  logic [NUM_CH-1:0]   acc, acc_d;
  logic [TS_W-1:0]     first_ts, first_ts_d;

  logic [HEADER_W-1:0] header_q;
  logic [TS_W-1:0]     counter_q;
  logic                valid_q;

  assign pins[HDR_AP] = bus.ap_pin;
  assign pins[HDR_VP] = bus.vp_pin;
  assign pins[HDR_RV] = bus.rv_pin;
  assign pins[HDR_RA] = bus.ra_pin;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_qualifier #(.BLANK_TICKS(BLANK_TICKS)) u_qual (
      .clk    (clk),
      .rst    (rst),
      .pin    (pins[i]),
      .accept (accept[i])
    );
  end

  assign any_accept = |accept;

  always_comb begin
    state_d    = state;
    win_cnt_d  = win_cnt;
    acc_d      = acc;
    first_ts_d = first_ts;
    case (state)
      IDLE, EMIT: begin
        // EMIT has already handed acc to the output registers, so an edge here
        // starts a fresh window exactly as it would from IDLE.
        acc_d   = '0;
        state_d = IDLE;
        if (any_accept) begin
          first_ts_d = ts;
          acc_d      = accept;
          if (MERGE_TICKS == 8'd0) begin
            state_d = EMIT;
          end else begin
            state_d   = COLLECT;
            win_cnt_d = MERGE_TICKS - 8'd1;
          end
        end
      end
      COLLECT: begin
        acc_d = acc | accept;
        if (win_cnt == 8'd0)
          state_d = EMIT;
        else
          win_cnt_d = win_cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts        <= TS_INIT;
      state     <= IDLE;
      win_cnt   <= '0;
      acc       <= '0;
      first_ts  <= '0;
      header_q  <= '0;
      counter_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      ts       <= ts + 1'b1;
      state    <= state_d;
      win_cnt  <= win_cnt_d;
      acc      <= acc_d;
      first_ts <= first_ts_d;
      // Outputs are loaded on entry to EMIT so the strobe lines up with that state.
      if (state_d == EMIT) begin
        valid_q   <= 1'b1;
        header_q  <= {{(HEADER_W-NUM_CH){1'b0}}, acc_d};
        counter_q <= first_ts_d;
      end else begin
        valid_q  <= 1'b0;
        header_q <= '0;
      end
    end
  end

  assign bus.header      = header_q;
  assign bus.counter     = counter_q;
  assign bus.event_valid = valid_q;

endmodule

// File: tb/tb_event_stamper.sv
// tb/tb_event_stamper.sv - self-checking bench for event_stamper
module tb_event_stamper;

  localparam int          BLANK = 150;
  localparam int          MERGE = 15;
  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFE6;

  logic clk;
  logic rst;
  logic rst2;

  event_stamper_if ifc ();
  event_stamper_if ifc2 ();

  event_stamper #(.BLANK_TICKS(32'd150), .MERGE_TICKS(8'd15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  event_stamper #(.BLANK_TICKS(32'd20), .MERGE_TICKS(8'd0), .TS_INIT(WRAP_INIT)) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (ifc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: rules stated on pin samples and cycle numbers.
  int unsigned cyc = 0;
  bit          model_ready = 0;
  bit          s1[4];
  bit          s2[4];
  bit          has_acc[4];
  int unsigned last_acc[4];
  bit          pend = 0;
  logic [7:0]  pend_bits;
  logic [31:0] pend_ts;
  int unsigned pend_emit;
  logic [31:0] ts_m = 0;
  logic        exp_valid = 0;
  logic [7:0]  exp_header = 0;
  logic [31:0] exp_counter = 0;

  always @(posedge clk) begin : model
    logic [3:0] p;
    logic [7:0] acc_bits;
    cyc++;
    p = {ifc.ra_pin, ifc.rv_pin, ifc.vp_pin, ifc.ap_pin};
    if (rst) begin
      model_ready = 1;
      ts_m        = 0;
      pend        = 0;
      exp_valid   = 0;
      exp_header  = 0;
      exp_counter = 0;
      for (int ch = 0; ch < 4; ch++) begin
        s2[ch]      = s1[ch];
        s1[ch]      = 0;
        has_acc[ch] = 0;
      end
    end else begin
      ts_m       = ts_m + 1;
      exp_valid  = 0;
      exp_header = 0;
      acc_bits   = 0;
      for (int ch = 0; ch < 4; ch++) begin
        if (s1[ch] && !s2[ch] && (!has_acc[ch] || (cyc - last_acc[ch]) >= BLANK)) begin
          acc_bits[ch] = 1;
          has_acc[ch]  = 1;
          last_acc[ch] = cyc;
        end
        s2[ch] = s1[ch];
        s1[ch] = p[ch];
      end
      if (pend && cyc == pend_emit) begin
        exp_valid   = 1;
        exp_header  = pend_bits;
        exp_counter = pend_ts;
        pend        = 0;
      end
      if (acc_bits != 0) begin
        if (pend) begin
          pend_bits = pend_bits | acc_bits;
        end else begin
          pend      = 1;
          pend_bits = acc_bits;
          pend_ts   = ts_m;
          pend_emit = cyc + MERGE + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_ready) begin
      checks++;
      if (ifc.event_valid !== exp_valid || ifc.header !== exp_header || ifc.counter !== exp_counter) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d actual v=%b h=%h c=%h required v=%b h=%h c=%h", cyc,
                 ifc.event_valid, ifc.header, ifc.counter, exp_valid, exp_header, exp_counter);
      end
    end
  end

  logic [7:0]  log_hdr[$];
  logic [31:0] log_cnt[$];
  int unsigned log_cyc[$];

  always @(negedge clk) begin : strobe_log
    if (ifc.event_valid === 1'b1) begin
      log_hdr.push_back(ifc.header);
      log_cnt.push_back(ifc.counter);
      log_cyc.push_back(cyc);
    end
  end

  initial begin : stim
    int unsigned r0, k, a, j;
    int          n0;
    logic [31:0] first_cnt;
    rst  = 1;
    rst2 = 1;
    {ifc.ap_pin, ifc.vp_pin, ifc.rv_pin, ifc.ra_pin}     = '0;
    {ifc2.ap_pin, ifc2.vp_pin, ifc2.rv_pin, ifc2.ra_pin} = '0;

    // Wrap instance: ts reset to WRAP_INIT, no merging, edges 40 ticks apart
    repeat (2) @(negedge clk);
    rst2 = 0;
    check("wrap_reset_counter", ifc2.counter, 32'd0);
    repeat (8) @(negedge clk);
    ifc2.rv_pin = 1;
    repeat (2) @(negedge clk);
    ifc2.rv_pin = 0;
    @(negedge clk);
    check("wrap_first_valid", {31'd0, ifc2.event_valid}, 32'd1);
    check("wrap_first_header", {24'd0, ifc2.header}, 32'h04);
    check("wrap_first_counter", ifc2.counter, 32'hFFFF_FFF0);
    first_cnt = ifc2.counter;
    @(negedge clk);
    check("wrap_one_cycle", {31'd0, ifc2.event_valid}, 32'd0);
    check("wrap_hold", ifc2.counter, 32'hFFFF_FFF0);
    repeat (36) @(negedge clk);
    ifc2.rv_pin = 1;
    repeat (2) @(negedge clk);
    ifc2.rv_pin = 0;
    @(negedge clk);
    check("wrap_second_valid", {31'd0, ifc2.event_valid}, 32'd1);
    check("wrap_second_counter", ifc2.counter, 32'd24);
    check("wrap_delta", ifc2.counter - first_cnt, 32'd40);

    // Reset state of the main instance
    @(negedge clk);
    r0  = cyc;
    rst = 0;
    check("reset_header", {24'd0, ifc.header}, 32'd0);
    check("reset_counter", ifc.counter, 32'd0);
    check("reset_valid", {31'd0, ifc.event_valid}, 32'd0);

    // Single rv pulse detected at ts=1000
    repeat (998) @(negedge clk);
    ifc.rv_pin = 1;
    repeat (2) @(negedge clk);
    ifc.rv_pin = 0;
    repeat (16) @(negedge clk);
    check("rv_valid", {31'd0, ifc.event_valid}, 32'd1);
    check("rv_header", {24'd0, ifc.header}, 32'h04);
    check("rv_counter", ifc.counter, 32'd1000);
    repeat (5) @(negedge clk);
    check("rv_hold_counter", ifc.counter, 32'd1000);
    check("rv_hold_valid", {31'd0, ifc.event_valid}, 32'd0);

    // vp then rv 5 cycles later merge into one header
    repeat (200) @(negedge clk);
    k = cyc;
    ifc.vp_pin = 1;
    repeat (5) @(negedge clk);
    ifc.vp_pin = 0;
    ifc.rv_pin = 1;
    repeat (2) @(negedge clk);
    ifc.rv_pin = 0;
    repeat (11) @(negedge clk);
    check("merge_valid", {31'd0, ifc.event_valid}, 32'd1);
    check("merge_header", {24'd0, ifc.header}, 32'h06);
    check("merge_counter", ifc.counter, k + 2 - r0);

    // Blanking: retrigger at +100 is dropped, +150 is accepted
    repeat (200) @(negedge clk);
    a  = cyc;
    n0 = log_cnt.size();
    ifc.rv_pin = 1; repeat (2) @(negedge clk); ifc.rv_pin = 0;
    repeat (98) @(negedge clk);
    ifc.rv_pin = 1; repeat (2) @(negedge clk); ifc.rv_pin = 0;
    repeat (48) @(negedge clk);
    ifc.rv_pin = 1; repeat (2) @(negedge clk); ifc.rv_pin = 0;
    repeat (48) @(negedge clk);
    check("blank_count", log_cnt.size(), n0 + 2);
    if (log_cnt.size() == n0 + 2) begin
      check("blank_delta", log_cnt[n0+1] - log_cnt[n0], 32'd150);
      check("blank_first_ts", log_cnt[n0], a + 2 - r0);
    end

    // ra edge in the EMIT cycle of an rv event opens a new window
    repeat (200) @(negedge clk);
    k  = cyc;
    n0 = log_cnt.size();
    ifc.rv_pin = 1; repeat (2) @(negedge clk); ifc.rv_pin = 0;
    repeat (14) @(negedge clk);
    ifc.ra_pin = 1; repeat (2) @(negedge clk); ifc.ra_pin = 0;
    repeat (30) @(negedge clk);
    check("emit_edge_count", log_cnt.size(), n0 + 2);
    if (log_cnt.size() == n0 + 2) begin
      check("emit_edge_hdr0", {24'd0, log_hdr[n0]}, 32'h04);
      check("emit_edge_hdr1", {24'd0, log_hdr[n0+1]}, 32'h08);
      check("emit_edge_gap", log_cyc[n0+1] - log_cyc[n0], 32'd16);
    end

    // Reset during COLLECT discards the pending event
    repeat (200) @(negedge clk);
    n0 = log_cnt.size();
    ifc.rv_pin = 1; repeat (2) @(negedge clk); ifc.rv_pin = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_header", {24'd0, ifc.header}, 32'd0);
    check("midrst_counter", ifc.counter, 32'd0);
    check("midrst_valid", {31'd0, ifc.event_valid}, 32'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_strobe", log_cnt.size(), n0);

    // Pin held high through reset release reports an edge after release
    ifc.ap_pin = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (18) @(negedge clk);
    check("held_valid", {31'd0, ifc.event_valid}, 32'd1);
    check("held_header", {24'd0, ifc.header}, 32'h01);
    check("held_counter", ifc.counter, 32'd2);
    ifc.ap_pin = 0;

    // Randomised traffic with occasional resets and coincident edges
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        {ifc.ap_pin, ifc.vp_pin, ifc.rv_pin, ifc.ra_pin} = 4'b0000;
      end else if ($urandom_range(0, 199) == 0) begin
        {ifc.ap_pin, ifc.vp_pin, ifc.rv_pin, ifc.ra_pin} = 4'b1111;
      end else begin
        if ($urandom_range(0, 15) == 0) ifc.ap_pin = ~ifc.ap_pin;
        if ($urandom_range(0, 15) == 0) ifc.vp_pin = ~ifc.vp_pin;
        if ($urandom_range(0, 15) == 0) ifc.rv_pin = ~ifc.rv_pin;
        if ($urandom_range(0, 15) == 0) ifc.ra_pin = ~ifc.ra_pin;
      end
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
